// File: rtl/fft_pingpong_ctrl_pkg.sv
// Shared definitions for the FFT ping-pong frame buffer controller:
// default geometry, read FSM state encoding and bank decode helper.
package fft_pingpong_ctrl_pkg;

   localparam int DRAMWIDTH_DEF = 32;
   localparam int ARAMWIDTH_DEF = 7;

   typedef logic [2:0] rd_state_t;

   localparam rd_state_t RD_IDLE  = 3'd0;
   localparam rd_state_t RD_START = 3'd1;
   localparam rd_state_t RD_WAIT  = 3'd2;
   localparam rd_state_t RD_BUSY  = 3'd3;
   localparam rd_state_t RD_DONE  = 3'd4;

   function automatic logic [1:0] bank_sel(input logic bank);
      bank_sel = bank ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/fft_pp_wr_side.sv
// Write side of the ping-pong controller: per-frame word counter, current
// write bank and the one-cycle registered RAM write port.
module fft_pp_wr_side
   import fft_pingpong_ctrl_pkg::*;
#(
   parameter int DRAMWIDTH = DRAMWIDTH_DEF,
   parameter int ARAMWIDTH = ARAMWIDTH_DEF
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 wr_valid_in,
   input  logic [DRAMWIDTH-1:0] wr_data_in,
   input  logic [1:0]           bank_full,
   output logic                 wr_ready,
   output logic [1:0]           set_full,
   output logic                 ram_wr_en,
   output logic [ARAMWIDTH:0]   ram_wr_addr,
   output logic [DRAMWIDTH-1:0] ram_wr_data
);

   logic [ARAMWIDTH-1:0] wr_cnt;
   logic                 wr_bank;
   logic                 wr_accept;
   logic                 last_word;

   logic                 vld_p1;
   logic [ARAMWIDTH:0]   wr_addr_p1;
   logic [DRAMWIDTH-1:0] wr_data_p1;

   assign wr_ready  = !bank_full[wr_bank];
   assign wr_accept = wr_valid_in && wr_ready;
   assign last_word = &wr_cnt;
   assign set_full  = (wr_accept && last_word) ? bank_sel(wr_bank) : 2'b00;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_cnt  <= '0;
         wr_bank <= 1'b0;
      end else if (wr_accept) begin
         wr_cnt <= wr_cnt + 1'b1;
         if (last_word)
            wr_bank <= ~wr_bank;
      end
   end

   // p0 -> p1: accepted word registered onto the RAM write port
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         vld_p1     <= 1'b0;
         wr_addr_p1 <= '0;
         wr_data_p1 <= '0;
      end else begin
         vld_p1 <= wr_accept;
         if (wr_accept) begin
            wr_addr_p1 <= {wr_bank, wr_cnt};
            wr_data_p1 <= wr_data_in;
         end
      end
   end

   assign ram_wr_en   = vld_p1;
   assign ram_wr_addr = wr_addr_p1;
   assign ram_wr_data = wr_data_p1;

endmodule

// File: rtl/fft_pingpong_ctrl.sv
// Ping-pong frame buffer controller for the FFT input RAM: one bank fills while the other is read.
// Define FFT_PP_OVERFLOW_CNT_EN to add ovf_cnt, a saturating count of words offered while blocked.
module fft_pingpong_ctrl
   import fft_pingpong_ctrl_pkg::*;
#(
   parameter int DRAMWIDTH = DRAMWIDTH_DEF,
   parameter int ARAMWIDTH = ARAMWIDTH_DEF
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 wr_valid_in,
   input  logic [DRAMWIDTH-1:0] wr_data_in,
   output logic                 wr_ready,
   output logic                 ram_wr_en,
   output logic [ARAMWIDTH:0]   ram_wr_addr,
   output logic [DRAMWIDTH-1:0] ram_wr_data,
   output logic                 rd_start,
   input  logic                 rd_en_in,
   output logic                 rd_bank,
   output logic                 frame_done,
   output logic [1:0]           bank_full
`ifdef FFT_PP_OVERFLOW_CNT_EN
   ,
   output logic [15:0]          ovf_cnt
`endif
);

   rd_state_t  rd_state;
   rd_state_t  rd_state_nxt;
   logic [1:0] set_full;
   logic [1:0] clr_full;

   fft_pp_wr_side #(
      .DRAMWIDTH (DRAMWIDTH),
      .ARAMWIDTH (ARAMWIDTH)
   ) u_wr_side (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .wr_valid_in (wr_valid_in),
      .wr_data_in  (wr_data_in),
      .bank_full   (bank_full),
      .wr_ready    (wr_ready),
      .set_full    (set_full),
      .ram_wr_en   (ram_wr_en),
      .ram_wr_addr (ram_wr_addr),
      .ram_wr_data (ram_wr_data)
   );

   always_comb begin
      rd_state_nxt = rd_state;
      case (rd_state)
         RD_IDLE:  if (bank_full[rd_bank]) rd_state_nxt = RD_START;
         RD_START: rd_state_nxt = RD_WAIT;
         RD_WAIT:  if (rd_en_in) rd_state_nxt = RD_BUSY;
         RD_BUSY:  if (!rd_en_in) rd_state_nxt = RD_DONE;
         RD_DONE:  rd_state_nxt = RD_IDLE;
         default:  rd_state_nxt = RD_IDLE;
      endcase
   end

   // Write-side set and read-side release always hit different banks, so both apply
   assign clr_full = (rd_state == RD_DONE) ? bank_sel(rd_bank) : 2'b00;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rd_state  <= RD_IDLE;
         rd_bank   <= 1'b0;
         bank_full <= 2'b00;
      end else begin
         rd_state  <= rd_state_nxt;
         bank_full <= (bank_full | set_full) & ~clr_full;
         if (rd_state == RD_DONE)
            rd_bank <= ~rd_bank;
      end
   end

   assign rd_start   = (rd_state == RD_START);
   assign frame_done = (rd_state == RD_DONE);

`ifdef FFT_PP_OVERFLOW_CNT_EN
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         ovf_cnt <= 16'h0000;
      else if (wr_valid_in && !wr_ready && (ovf_cnt != 16'hFFFF))
         ovf_cnt <= ovf_cnt + 16'h0001;
   end
`endif

endmodule

// File: tb/tb_fft_pingpong_ctrl.sv
// Directed bench for fft_pingpong_ctrl with 8-word frames: vector table for a
// single frame plus hand sequences for back-pressure, reset and bank overlap.
module tb_fft_pingpong_ctrl;

   localparam int DW = 32;
   localparam int AW = 3;
   localparam int FW = 1 << AW;

   logic          clk_in = 1'b0;
   logic          rst_n_in;
   logic          wr_valid_in;
   logic [DW-1:0] wr_data_in;
   logic          wr_ready;
   logic          ram_wr_en;
   logic [AW:0]   ram_wr_addr;
   logic [DW-1:0] ram_wr_data;
   logic          rd_start;
   logic          rd_en_in;
   logic          rd_bank;
   logic          frame_done;
   logic [1:0]    bank_full;
`ifdef FFT_PP_OVERFLOW_CNT_EN
   logic [15:0]   ovf_cnt;
`endif

   fft_pingpong_ctrl #(.DRAMWIDTH(DW), .ARAMWIDTH(AW)) dut (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .wr_valid_in (wr_valid_in),
      .wr_data_in  (wr_data_in),
      .wr_ready    (wr_ready),
      .ram_wr_en   (ram_wr_en),
      .ram_wr_addr (ram_wr_addr),
      .ram_wr_data (ram_wr_data),
      .rd_start    (rd_start),
      .rd_en_in    (rd_en_in),
      .rd_bank     (rd_bank),
      .frame_done  (frame_done),
      .bank_full   (bank_full)
`ifdef FFT_PP_OVERFLOW_CNT_EN
      ,
      .ovf_cnt     (ovf_cnt)
`endif
   );

   always #5 clk_in = ~clk_in;

   logic [DW-1:0] mem [0:2*FW-1];
   always @(posedge clk_in) if (ram_wr_en === 1'b1) mem[ram_wr_addr] <= ram_wr_data;

   int fd_total = 0;
   always @(posedge clk_in) if (frame_done === 1'b1) fd_total <= fd_total + 1;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rst_n_in = 1'b0;
      wr_valid_in = 1'b0;
      wr_data_in = '0;
      rd_en_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;
   endtask

   typedef struct {
      logic          wv;
      logic [DW-1:0] wd;
      logic          re;
      logic          e_ready;
      logic          e_wen;
      logic [AW:0]   e_addr;
      logic [DW-1:0] e_wdata;
      logic [1:0]    e_full;
      logic          e_start;
      logic          e_rdbank;
      logic          e_done;
   } vec_t;

   localparam int NV = 21;
   vec_t vt [NV];

   task automatic row(input int k, input logic wv, input logic [DW-1:0] wd, input logic re,
                      input logic e_ready, input logic e_wen, input logic [AW:0] e_addr,
                      input logic [DW-1:0] e_wdata, input logic [1:0] e_full,
                      input logic e_start, input logic e_rdbank, input logic e_done);
      vt[k] = '{wv:wv, wd:wd, re:re, e_ready:e_ready, e_wen:e_wen, e_addr:e_addr,
                e_wdata:e_wdata, e_full:e_full, e_start:e_start, e_rdbank:e_rdbank, e_done:e_done};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam logic [DW-1:0] D0 = 32'hA5A5_0000;

   initial begin : main
      logic [AW:0]   ea;
      logic [DW-1:0] base;
      int            cnt;
      int            fd0;
      logic          banks [$];
      logic [DW-1:0] rq [$];

      // single frame: 8 words, then reader raises read_en 1 cycle after rd_start for 8 cycles
      for (int k = 0; k < FW; k++) begin
         ea = k[AW:0];
         row(k, 1'b1, D0 + k, 1'b0, 1'b1, 1'b1, ea, D0 + k, (k == FW-1) ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b0);
      end
      row(8,  1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 2'b01, 1'b1, 1'b0, 1'b0);
      row(9,  1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 2'b01, 1'b0, 1'b0, 1'b0);
      for (int k = 10; k < 18; k++)
         row(k, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0, '0, 2'b01, 1'b0, 1'b0, 1'b0);
      row(18, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 2'b01, 1'b0, 1'b0, 1'b1);
      row(19, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
      row(20, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0);

      do_reset();
      chk("rst_wr_ready", wr_ready, 1'b1);
      chk("rst_ram_wr_en", ram_wr_en, 1'b0);
      chk("rst_bank_full", bank_full, 2'b00);
      chk("rst_rd_start", rd_start, 1'b0);
      chk("rst_rd_bank", rd_bank, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);

      for (int k = 0; k < NV; k++) begin
         wr_valid_in = vt[k].wv;
         wr_data_in  = vt[k].wd;
         rd_en_in    = vt[k].re;
         tick();
         chk($sformatf("v%0d_wr_ready", k), wr_ready, vt[k].e_ready);
         chk($sformatf("v%0d_ram_wr_en", k), ram_wr_en, vt[k].e_wen);
         if (vt[k].e_wen) begin
            chk($sformatf("v%0d_ram_wr_addr", k), ram_wr_addr, vt[k].e_addr);
            chk($sformatf("v%0d_ram_wr_data", k), ram_wr_data, vt[k].e_wdata);
         end
         chk($sformatf("v%0d_bank_full", k), bank_full, vt[k].e_full);
         chk($sformatf("v%0d_rd_start", k), rd_start, vt[k].e_start);
         chk($sformatf("v%0d_rd_bank", k), rd_bank, vt[k].e_rdbank);
         chk($sformatf("v%0d_frame_done", k), frame_done, vt[k].e_done);
      end

      // both banks full with a stalled reader, then the first release
      do_reset();
      base = 32'h1000_0000;
      for (int w = 0; w < 2*FW; w++) begin
         wr_valid_in = 1'b1;
         wr_data_in = base + w;
         tick();
      end
      chk("bp_wr_ready_low", wr_ready, 1'b0);
      chk("bp_bank_full", bank_full, 2'b11);
      chk("bp_rd_bank", rd_bank, 1'b0);
      wr_data_in = base + 2*FW;
      cnt = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (ram_wr_en !== 1'b0 || wr_ready !== 1'b0) cnt++;
      end
      chk("bp_stall_no_activity", cnt, 0);
      chk("bp_stall_rd_start", rd_start, 1'b0);
      rd_en_in = 1'b1;
      repeat (FW) tick();
      rd_en_in = 1'b0;
      tick();
      chk("bp_done_pulse", frame_done, 1'b1);
      chk("bp_done_wr_ready", wr_ready, 1'b0);
      tick();
      chk("bp_after_done_wr_ready", wr_ready, 1'b1);
      chk("bp_after_done_full", bank_full, 2'b10);
      for (int j = 0; j < FW; j++) begin
         wr_data_in = base + 2*FW + j;
         tick();
         ea = j[AW:0];
         chk($sformatf("bp_w%0d_en", j + 17), ram_wr_en, 1'b1);
         chk($sformatf("bp_w%0d_addr", j + 17), ram_wr_addr, ea);
         chk($sformatf("bp_w%0d_data", j + 17), ram_wr_data, base + 2*FW + j);
      end
      wr_valid_in = 1'b0;

      // three frames streamed through a RAM model and a reader model
      do_reset();
      base = 32'hC000_0000;
      fd0 = fd_total;
      fork
         begin : writer
            int w;
            int b;
            logic acc;
            w = 0;
            b = 0;
            while (w < 3*FW && b < 400) begin
               wr_valid_in = 1'b1;
               wr_data_in = base + w;
               acc = wr_ready;
               tick();
               if (acc) w++;
               b++;
            end
            wr_valid_in = 1'b0;
            chk("ff_writer_done", w, 3*FW);
         end
         begin : reader
            int b;
            logic [AW-1:0] idx;
            for (int f = 0; f < 3; f++) begin
               b = 0;
               while (rd_start !== 1'b1 && b < 300) begin
                  tick();
                  b++;
               end
               chk($sformatf("ff_start%0d_seen", f), (b < 300), 1'b1);
               banks.push_back(rd_bank);
               tick();
               rd_en_in = 1'b1;
               for (int i = 0; i < FW; i++) begin
                  idx = i[AW-1:0];
                  rq.push_back(mem[{rd_bank, idx}]);
                  if (i < FW-1) tick();
               end
               tick();
               rd_en_in = 1'b0;
            end
         end
      join
      repeat (4) tick();
      chk("ff_frame_done_count", fd_total - fd0, 3);
      chk("ff_banks_len", banks.size(), 3);
      if (banks.size() == 3) begin
         chk("ff_bank0", banks[0], 1'b0);
         chk("ff_bank1", banks[1], 1'b1);
         chk("ff_bank2", banks[2], 1'b0);
      end
      chk("ff_read_len", rq.size(), 3*FW);
      cnt = 0;
      for (int i = 0; i < rq.size(); i++)
         if (rq[i] !== base + i) cnt++;
      chk("ff_read_order_errors", cnt, 0);
      chk("ff_final_full", bank_full, 2'b00);

      // reset in the middle of a frame
      do_reset();
      base = 32'h5500_0000;
      for (int w = 0; w < 5; w++) begin
         wr_valid_in = 1'b1;
         wr_data_in = base + w;
         tick();
      end
      wr_valid_in = 1'b0;
      rst_n_in = 1'b0;
      #2;
      chk("mr_wr_ready", wr_ready, 1'b1);
      chk("mr_ram_wr_en", ram_wr_en, 1'b0);
      chk("mr_ram_wr_addr", ram_wr_addr, 4'd0);
      chk("mr_ram_wr_data", ram_wr_data, 32'd0);
      chk("mr_bank_full", bank_full, 2'b00);
      chk("mr_rd_start", rd_start, 1'b0);
      chk("mr_rd_bank", rd_bank, 1'b0);
      chk("mr_frame_done", frame_done, 1'b0);
      @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;
      cnt = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (rd_start !== 1'b0) cnt++;
      end
      chk("mr_no_rd_start", cnt, 0);
      base = 32'h6600_0000;
      for (int j = 0; j < FW; j++) begin
         wr_valid_in = 1'b1;
         wr_data_in = base + j;
         tick();
         ea = j[AW:0];
         chk($sformatf("mr_w%0d_addr", j), ram_wr_addr, ea);
         chk($sformatf("mr_w%0d_data", j), ram_wr_data, base + j);
      end
      wr_valid_in = 1'b0;
      chk("mr_refill_full", bank_full, 2'b01);

      // bank 1 completes on the same edge that releases bank 0
      do_reset();
      base = 32'h7700_0000;
      for (int w = 0; w < 2*FW-1; w++) begin
         wr_valid_in = 1'b1;
         wr_data_in = base + w;
         tick();
      end
      wr_valid_in = 1'b0;
      rd_en_in = 1'b1;
      tick();
      rd_en_in = 1'b0;
      tick();
      chk("ov_done_pulse", frame_done, 1'b1);
      chk("ov_pre_full", bank_full, 2'b01);
      wr_valid_in = 1'b1;
      wr_data_in = base + 2*FW - 1;
      tick();
      wr_valid_in = 1'b0;
      chk("ov_post_full", bank_full, 2'b10);
      chk("ov_rd_bank", rd_bank, 1'b1);
      chk("ov_done_cleared", frame_done, 1'b0);
      chk("ov_last_addr", ram_wr_addr, 4'd15);
      chk("ov_last_data", ram_wr_data, base + 2*FW - 1);
      chk("ov_wr_ready", wr_ready, 1'b1);
      tick();
      chk("ov_next_start", rd_start, 1'b1);

`ifdef FFT_PP_OVERFLOW_CNT_EN
      // overflow counter while both banks are full
      do_reset();
      for (int w = 0; w < 2*FW; w++) begin
         wr_valid_in = 1'b1;
         wr_data_in = w;
         tick();
      end
      wr_valid_in = 1'b0;
      tick();
      chk("ovf_zero", ovf_cnt, 16'd0);
      wr_valid_in = 1'b1;
      repeat (10) tick();
      wr_valid_in = 1'b0;
      tick();
      chk("ovf_ten", ovf_cnt, 16'd10);
      force dut.ovf_cnt = 16'hFFFE;
      tick();
      release dut.ovf_cnt;
      tick();
      chk("ovf_preload", ovf_cnt, 16'hFFFE);
      wr_valid_in = 1'b1;
      repeat (5) tick();
      wr_valid_in = 1'b0;
      tick();
      chk("ovf_saturate", ovf_cnt, 16'hFFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_pingpong_ctrl.md
FFT_PINGPONG_CTRL -- requirements
Module: fft_pingpong_ctrl

Interface
REQ-001 Parameter DRAMWIDTH, default 32: RAM word width, {im,re} packed.
REQ-002 Parameter ARAMWIDTH, default 7: address width of one bank; frame = 2^ARAMWIDTH words.
REQ-003 clk_in  input  1  sole clock, rising edge.
REQ-004 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 wr_valid_in  input  1  source word valid.
REQ-006 wr_data_in  input  DRAMWIDTH  source word.
REQ-007 wr_ready  output  1  controller accepts a word this cycle.
REQ-008 ram_wr_en  output  1  RAM write strobe.
REQ-009 ram_wr_addr  output  ARAMWIDTH+1  write address; MSB = bank.
REQ-010 ram_wr_data  output  DRAMWIDTH  write data.
REQ-011 rd_start  output  1  one-cycle start pulse to the frame reader's en_in.
REQ-012 rd_en_in  input  1  reader's read_en; high while the reader walks a frame.
REQ-013 rd_bank  output  1  bank the reader addresses (reader address MSB).
REQ-014 frame_done  output  1  one-cycle pulse when a bank is released.
REQ-015 bank_full  output  2  per-bank full flags.

Function
REQ-016 Write handshake SHALL be wr_valid_in && wr_ready; wr_ready = !bank_full[wr_bank] (combinational from registers only).
REQ-017 An accepted word SHALL appear on ram_wr_en/ram_wr_addr/ram_wr_data exactly 1 cycle later; ram_wr_en low otherwise.
REQ-018 wr_cnt (ARAMWIDTH bits) SHALL increment per accepted word; on the accepted word at wr_cnt = all-ones it wraps to 0, bank_full[wr_bank] sets and wr_bank toggles.
REQ-019 Read FSM states: IDLE, START, WAIT, BUSY, DONE.
REQ-020 IDLE -> START when bank_full[rd_bank]=1.
REQ-021 START: rd_start=1 for exactly this one cycle; -> WAIT.
REQ-022 WAIT -> BUSY when rd_en_in=1; stays in WAIT otherwise (no timeout).
REQ-023 BUSY -> DONE when rd_en_in=0.
REQ-024 DONE: clear bank_full[rd_bank], toggle rd_bank, pulse frame_done; -> IDLE.
REQ-025 Set (write side) and clear (read side) in the same cycle SHALL both take effect; they always target different banks.
REQ-026 rd_bank SHALL be stable from START through DONE.
REQ-027 Both banks full: wr_ready=0 until a DONE frees a bank; wr_ready rises the cycle after DONE.
REQ-028 Word order within a frame SHALL be preserved; banks are consumed in the order filled.

Reset
REQ-029 On rst_n_in low: FSM=IDLE, wr_bank=0, rd_bank=0, wr_cnt=0, bank_full=2'b00, ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, rd_start=0, frame_done=0; wr_ready=1 after reset.
REQ-030 Reset mid-frame SHALL discard the partial frame and all full flags; no rd_start is issued until a new full frame is written.

Configuration
REQ-031 Macro FFT_PP_OVERFLOW_CNT_EN defined: extra output ovf_cnt (16 bits) counts cycles with wr_valid_in=1 && wr_ready=0, saturating at 16'hFFFF, reset to 0.
REQ-032 Macro undefined: no ovf_cnt port, no counter logic; all other behaviour identical.

Structure
REQ-033 Shared package SHALL hold the FSM state encoding (3-bit: IDLE=0, START=1, WAIT=2, BUSY=3, DONE=4) and default parameter values.
REQ-034 Sub-module fft_pp_wr_side SHALL hold wr_cnt, wr_bank and the registered write port; the read FSM and bank_full live in the top.

Verification
REQ-035 ARAMWIDTH=3, 8 back-to-back words, reader model (read_en high 8 cycles, starting 1 cycle after en_in) -> writes addr 0..7, bank_full=01, rd_start 1 cycle after full, rd_bank=0, frame_done after read_en falls.
REQ-036 ARAMWIDTH=3, 24 continuous words, reader stalled 30 cycles -> wr_ready=0 after word 16, bank_full=11; first DONE restores wr_ready next cycle; words 17..24 land at addr 0..7 (bank 0).
REQ-037 Three frames -> rd_bank sequence 0,1,0; frame_done count 3; read data order matches write order.
REQ-038 rst_n_in low after 5 of 8 words -> all outputs at reset values; next 8 words fill bank 0 from addr 0.
REQ-039 Frame completion on the same cycle as DONE for the other bank -> bank_full ends with the new bit set and the released bit clear.
REQ-040 With FFT_PP_OVERFLOW_CNT_EN, hold wr_valid_in=1 for 10 cycles while both banks are full -> ovf_cnt=10; preload 16'hFFFE plus 5 overflow cycles -> 16'hFFFF.
